usb_bit_unstuff: RTL and testbench
==================================

Name: usb_bit_unstuff

Overview:
- RX-path counterpart of the TX bit stuffer. Sits between the NRZI decoder and the RX shift register/PID stage in the SIE.
- Counts consecutive ones in the decoded bit stream. After MAX_ONES ones, the next bit must be a stuffed 0; that bit is removed from the stream.
- A 1 in the stuff position is a bit-stuff error. The block then discards bits until the packet ends or reset.

Parameters:
- MAX_ONES, 6: consecutive ones after which one stuffed 0 is expected. Legal range 1..15.

Ports:
- clk12_i  input  1  12 MHz SIE clock.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  data_i holds a decoded bit this cycle.
- data_i  input  1  decoded (post-NRZI) bit.
- eop_i  input  1  one-cycle strobe at packet end (SE0/EOP detected); clears run state and error.
- valid_o  output  1  data_o holds a payload bit this cycle.
- data_o  output  1  unstuffed payload bit.
- dropped_o  output  1  one-cycle pulse: a stuffed 0 was removed.
- stuffErr_o  output  1  one-cycle pulse on the cycle the error is detected.
- error_o  output  1  level; high from the error until eop_i or rst_i.

Behaviour:
- Interface decision: one clock, clk12_i. Reset rst_i is synchronous and active-high.
- All outputs are registered. Latency is 1 cycle from a valid_i sample to the corresponding valid_o/dropped_o/stuffErr_o.
- Reset values: valid_o=0, data_o=0, dropped_o=0, stuffErr_o=0, error_o=0, oneCounter=0, state=COUNT.
- oneCounter width is $clog2(MAX_ONES+1). It never exceeds MAX_ONES and never wraps.
- States: COUNT, EXPECT_STUFF, ERROR.
- Any cycle with valid_i=0 and eop_i=0:
  - state and oneCounter hold;
  - valid_o, dropped_o and stuffErr_o are 0 next cycle;
  - data_o holds its last value.
  - Gaps in valid_i inside a run of ones do not break the run.
- COUNT with valid_i=1:
  - valid_o<=1, data_o<=data_i.
  - data_i=0: oneCounter<=0.
  - data_i=1: oneCounter<=oneCounter+1. If the new value equals MAX_ONES, state<=EXPECT_STUFF.
- EXPECT_STUFF with valid_i=1:
  - data_i=0: stuff bit. valid_o<=0, dropped_o<=1, oneCounter<=0, state<=COUNT.
  - data_i=1: stuff error. valid_o<=0, stuffErr_o<=1, error_o<=1, state<=ERROR.
- ERROR:
  - Every valid_i bit is discarded: valid_o=0, dropped_o=0, stuffErr_o stays 0 after the first pulse.
  - error_o stays 1.
- eop_i=1, in any state: oneCounter<=0, state<=COUNT, error_o<=0, valid_o<=0, dropped_o<=0, stuffErr_o<=0.
- Simultaneous eop_i and valid_i: eop_i wins and the bit is discarded.
- Run of MAX_ONES ones followed directly by eop_i: no error, no dropped_o pulse.
- rst_i has priority over eop_i and valid_i. Reset mid-run or mid-ERROR returns to reset values on the next edge.
- With MAX_ONES=1, every 1 must be followed by a stuffed 0. The same rules apply.

Decomposition:
- Shared SIE package holds:
  - usb_unstuff_state_t enum {COUNT, EXPECT_STUFF, ERROR};
  - constant USB_BIT_STUFF_MAX_ONES=6. The TX stuffer and this block both default to it.
- No sub-module: the counter and FSM are small and tightly coupled. Keep them in one module.

Test Plan:
- Six 1s, then a 0, then 1,0 (back-to-back valid_i):
  - valid_o pulses 8 times with data 1,1,1,1,1,1,1,0;
  - the 7th input bit is absent from the output;
  - dropped_o is high exactly 1 cycle after the 7th input; error_o=0.
- Five 1s then a 0: all six bits appear on data_o; dropped_o never asserts.
- Seven 1s:
  - six bits are output;
  - stuffErr_o pulses 1 cycle after the 7th input and error_o rises;
  - then feed 0,1,0: valid_o stays 0 and error_o stays 1;
  - after an eop_i pulse, error_o=0 and the next bit 1 is output.
- Six 1s with 3-cycle valid_i gaps between each, then 0: the run is still counted and the 0 is dropped (dropped_o=1).
- Three 1s, then rst_i for 1 cycle, then six 1s and a 0: counter was cleared, so exactly one stuffed 0 is removed. Outputs are 0 in the cycle after reset.
- eop_i and valid_i (data_i=1) in the same cycle while in EXPECT_STUFF: no stuffErr_o, valid_o=0, state=COUNT with oneCounter=0.

Source files
------------

// File: rtl/usb_bit_unstuff_pkg.sv
// Shared SIE definitions for the bit-stuff path: the receive unstuffer
// state encoding and the run length the TX stuffer and RX unstuffer share.
package usb_bit_unstuff_pkg;

    // Ones in a row after which the line carries one stuffed zero.
    localparam int USB_BIT_STUFF_MAX_ONES = 6;

    typedef enum logic [1:0] {
        COUNT        = 2'd0,
        EXPECT_STUFF = 2'd1,
        ERROR        = 2'd2
    } usb_unstuff_state_t;

endpackage : usb_bit_unstuff_pkg

// File: rtl/usb_bit_unstuff.sv
// RX bit unstuffer: removes the zero inserted after MAX_ONES consecutive
// ones, flags a one in the stuff position as an error and discards the
// rest of the packet until EOP or reset. All outputs are registered with
// one cycle of latency.
module usb_bit_unstuff
    import usb_bit_unstuff_pkg::*;
#(
    parameter int MAX_ONES = USB_BIT_STUFF_MAX_ONES
) (
    input  logic clk12_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic data_i,
    input  logic eop_i,
    output logic valid_o,
    output logic data_o,
    output logic dropped_o,
    output logic stuffErr_o,
    output logic error_o
);

    localparam int CW = $clog2(MAX_ONES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ONES);

    usb_unstuff_state_t state_q, state_d;
    logic [CW-1:0]      one_counter_q, one_counter_d;
    logic [CW-1:0]      one_counter_inc;
    logic               valid_q, valid_d;
    logic               data_q, data_d;
    logic               dropped_q, dropped_d;
    logic               stuff_err_q, stuff_err_d;
    logic               error_q, error_d;

    // Next-state and next-output decode; EOP overrides any bit arriving with it.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        one_counter_d   = one_counter_q;
        valid_d         = 1'b0;
        data_d          = data_q;
        dropped_d       = 1'b0;
        stuff_err_d     = 1'b0;
        error_d         = error_q;
        // The counter never reaches MAX_CNT while in COUNT, so this cannot wrap.
        one_counter_inc = one_counter_q + 1'b1;

        if (eop_i) begin
            state_d       = COUNT;
            one_counter_d = '0;
            error_d       = 1'b0;
        end else if (valid_i) begin
            case (state_q)
                COUNT: begin
                    valid_d = 1'b1;
                    data_d  = data_i;
                    if (data_i) begin
                        one_counter_d = one_counter_inc;
                        if (one_counter_inc == MAX_CNT) begin
                            state_d = EXPECT_STUFF;
                        end
                    end else begin
                        one_counter_d = '0;
                    end
                end
                EXPECT_STUFF: begin
                    if (!data_i) begin
                        dropped_d     = 1'b1;
                        one_counter_d = '0;
                        state_d       = COUNT;
                    end else begin
                        stuff_err_d = 1'b1;
                        error_d     = 1'b1;
                        state_d     = ERROR;
                    end
                end
                ERROR: begin
                    // Bits are swallowed until the packet ends.
                end
                default: begin
                    state_d       = COUNT;
                    one_counter_d = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk12_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q       <= COUNT;
            one_counter_q <= '0;
            valid_q       <= 1'b0;
            data_q        <= 1'b0;
            dropped_q     <= 1'b0;
            stuff_err_q   <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            one_counter_q <= one_counter_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            dropped_q     <= dropped_d;
            stuff_err_q   <= stuff_err_d;
            error_q       <= error_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign dropped_o  = dropped_q;
    assign stuffErr_o = stuff_err_q;
    assign error_o    = error_q;

endmodule : usb_bit_unstuff

// File: tb/tb_usb_bit_unstuff.sv
// Directed bench for usb_bit_unstuff. Each step applies one input vector
// {rst, valid, data, eop} and then compares the registered outputs
// {valid_o, data_o, dropped_o, stuffErr_o, error_o} against a hand-derived
// vector. A second instance with MAX_ONES=1 covers the minimum run length.
module tb_usb_bit_unstuff;

    localparam logic [3:0] IDLE  = 4'b0000;
    localparam logic [3:0] ONE   = 4'b0110;
    localparam logic [3:0] ZERO  = 4'b0100;
    localparam logic [3:0] EOP   = 4'b0001;
    localparam logic [3:0] EOPV1 = 4'b0111;
    localparam logic [3:0] RST   = 4'b1000;

    logic clk12_i = 1'b0;
    logic rst_i   = 1'b1;
    logic valid_i = 1'b0;
    logic data_i  = 1'b0;
    logic eop_i   = 1'b0;

    logic valid_o, data_o, dropped_o, stuffErr_o, error_o;
    logic valid1_o, data1_o, dropped1_o, stuff_err1_o, error1_o;
    logic [4:0] obs, obs1;

    int checks = 0;
    int errors = 0;

    always #5 clk12_i = ~clk12_i;

    usb_bit_unstuff #(.MAX_ONES(6)) dut (
        .clk12_i    (clk12_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .eop_i      (eop_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .dropped_o  (dropped_o),
        .stuffErr_o (stuffErr_o),
        .error_o    (error_o)
    );

    usb_bit_unstuff #(.MAX_ONES(1)) dut1 (
        .clk12_i    (clk12_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .eop_i      (eop_i),
        .valid_o    (valid1_o),
        .data_o     (data1_o),
        .dropped_o  (dropped1_o),
        .stuffErr_o (stuff_err1_o),
        .error_o    (error1_o)
    );

    assign obs  = {valid_o, data_o, dropped_o, stuffErr_o, error_o};
    assign obs1 = {valid1_o, data1_o, dropped1_o, stuff_err1_o, error1_o};

    // Apply one vector away from the edge, then settle just past the edge.
    task automatic step(input logic [3:0] v);
        @(negedge clk12_i);
        rst_i   = v[3];
        valid_i = v[2];
        data_i  = v[1];
        eop_i   = v[0];
        @(posedge clk12_i);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(RST);
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset dut step %0d: got %b expected 00000", i, obs);
            end
            checks++;
            if (obs1 !== 5'b00000) begin
                errors++;
                $display("FAIL reset dut1 step %0d: got %b expected 00000", i, obs1);
            end
        end
    endtask

    task automatic test_max_ones_1();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        st = '{ONE, ZERO, ONE, ZERO, ONE, ONE, ZERO, EOP};
        ex = '{5'b11000, 5'b01100, 5'b11000, 5'b01100,
               5'b11000, 5'b01011, 5'b01001, 5'b01000};
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            checks++;
            if (obs1 !== ex[i]) begin
                errors++;
                $display("FAIL max_ones_1 step %0d: got %b expected %b", i, obs1, ex[i]);
            end
        end
    endtask

    task automatic test_stuff_drop();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        int pulses = 0;
        st = '{ONE, ONE, ONE, ONE, ONE, ONE, ZERO, ONE, ZERO, IDLE, EOP};
        ex = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000,
               5'b01100, 5'b11000, 5'b10000, 5'b00000, 5'b00000};
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            if (valid_o === 1'b1) pulses++;
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL stuff_drop step %0d: got %b expected %b", i, obs, ex[i]);
            end
        end
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL stuff_drop valid_count: got %0d expected 8", pulses);
        end
    endtask

    task automatic test_no_stuff();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        st = '{ONE, ONE, ONE, ONE, ONE, ZERO, EOP};
        ex = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000,
               5'b10000, 5'b00000};
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL no_stuff step %0d: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_stuff_error();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        st = '{ONE, ONE, ONE, ONE, ONE, ONE, ONE, ZERO, ONE, ZERO, EOP, ONE, EOP};
        ex = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000,
               5'b01011, 5'b01001, 5'b01001, 5'b01001, 5'b01000, 5'b11000,
               5'b01000};
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL stuff_error step %0d: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        for (int b = 0; b < 6; b++) begin
            st.push_back(ONE);
            ex.push_back(5'b11000);
            for (int g = 0; g < 3; g++) begin
                st.push_back(IDLE);
                ex.push_back(5'b01000);
            end
        end
        st.push_back(ZERO); ex.push_back(5'b01100);
        st.push_back(ONE);  ex.push_back(5'b11000);
        st.push_back(EOP);  ex.push_back(5'b01000);
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL gaps step %0d: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_eop_in_expect();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        st = '{ONE, ONE, ONE, ONE, ONE, ONE, EOPV1,
               ONE, ONE, ONE, ONE, ONE, ONE, ZERO, EOP};
        ex = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000,
               5'b01000,
               5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000,
               5'b01100, 5'b01000};
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL eop_in_expect step %0d: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_eop_after_run();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        st = '{ONE, ONE, ONE, ONE, ONE, ONE, EOP, ZERO, EOP};
        ex = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000,
               5'b01000, 5'b10000, 5'b00000};
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL eop_after_run step %0d: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] st[$];
        logic [4:0] ex[$];
        st = '{ONE, ONE, ONE, RST, ONE, ONE, ONE, ONE, ONE, ONE, ZERO, ZERO, EOP};
        ex = '{5'b11000, 5'b11000, 5'b11000, 5'b00000,
               5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000,
               5'b01100, 5'b10000, 5'b00000};
        for (int i = 0; i < st.size(); i++) begin
            step(st[i]);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL reset_mid_run step %0d: got %b expected %b", i, obs, ex[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max_ones_1();
        test_stuff_drop();
        test_no_stuff();
        test_stuff_error();
        test_gaps();
        test_eop_in_expect();
        test_eop_after_run();
        test_reset_mid_run();
        step(IDLE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_usb_bit_unstuff
